// File: rtl/if_fetch_if.sv
// if_fetch_if: bundles the instruction-memory read port and the decode-side
// output port of the fetch stage.
//
// Signals
//   imem_req   fetch -> memory  read request
//   imem_addr  fetch -> memory  read address, stable while imem_req is high and unacked
//   imem_ack   memory -> fetch  read data valid, only meaningful while imem_req is high
//   imem_rdata memory -> fetch  instruction word, sampled when imem_ack is high
//   id_valid   fetch -> decode  buffer head is valid
//   id_ready   decode -> fetch  decode takes the head
//   id_instr   fetch -> decode  head instruction (0 when empty)
//   id_pc      fetch -> decode  head PC (0 when empty)
//
// Handshakes: a transfer happens on a rising clk edge where the initiator's
// request/valid and the responder's ack/ready are both high. imem_ack may be
// high in the same cycle imem_req first rises. id_valid does not depend on
// id_ready, and imem_req does not depend on id_ready.
//
// Modports
//   master : the fetch stage
//   slave  : the memory/decode environment
interface if_fetch_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ack;
   logic [15:0] imem_rdata;
   logic        id_valid;
   logic        id_ready;
   logic [15:0] id_instr;
   logic [15:0] id_pc;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc,
      input  imem_ack, imem_rdata, id_ready
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc,
      output imem_ack, imem_rdata, id_ready
   );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage behind the PC register.
// Reads instruction memory at the current PC, advances the PC (pc_en) when an
// instruction returns, buffers {pc, instr} pairs and hands them to decode.
// A flush (branch redirect) empties the buffer; a fetch that is still in
// flight at that moment is waited out in DROP and its data thrown away.
//
// Configuration macro: IF_FETCH_SKID_EN
//   defined   : two-entry buffer, one instruction per cycle into decode
//   undefined : one-entry buffer, one instruction every two cycles
//
// Ports
//   clk        clock, all state on posedge
//   rst        synchronous active-high reset
//   pc_addr    current PC from the PC register
//   pc_en      PC advances (or loads its branch target) at the next edge
//   flush      branch redirect, same cycle the PC register sees it
//   bus        if_fetch_if.master: imem read port and decode output port
//   dbg_state  1 while in DROP
//   dbg_count  number of buffered entries
module if_fetch (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] pc_addr,
   output logic        pc_en,
   input  logic        flush,
   if_fetch_if.master  bus,
   output logic        dbg_state,
   output logic [1:0]  dbg_count
);

`ifdef IF_FETCH_SKID_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif

   typedef enum logic {RUN = 1'b0, DROP = 1'b1} state_t;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
   } entry_t;

   state_t      state;
   logic [1:0]  count;
   logic [15:0] drop_addr;
   entry_t      head;
`ifdef IF_FETCH_SKID_EN
   entry_t      tail;
`endif

   logic   req;
   logic   ack;
   logic   push;
   logic   pop;
   logic   valid;
   entry_t new_entry;

   // req depends only on registered state, never on id_ready, so a full
   // buffer blocks the request even in the cycle it is being popped.
   always_comb begin
      req       = (state == DROP) || (count < DEPTH);
      ack       = req && bus.imem_ack;
      push      = (state == RUN) && ack && !flush;
      valid     = (count != 2'd0) && !flush;
      pop       = valid && bus.id_ready;
      new_entry = '{pc: pc_addr, instr: bus.imem_rdata};
   end

   assign bus.imem_req  = !rst && req;
   assign bus.imem_addr = rst ? 16'h0000 : ((state == DROP) ? drop_addr : pc_addr);
   assign pc_en         = !rst && (((state == RUN) && ack) || flush);
   assign bus.id_valid  = !rst && valid;
   assign bus.id_pc     = (rst || count == 2'd0) ? 16'h0000 : head.pc;
   assign bus.id_instr  = (rst || count == 2'd0) ? 16'h0000 : head.instr;
   assign dbg_state     = (state == DROP);
   assign dbg_count     = count;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         count     <= 2'd0;
         drop_addr <= 16'h0000;
         head      <= '0;
`ifdef IF_FETCH_SKID_EN
         tail      <= '0;
`endif
      end else if (flush) begin
         count <= 2'd0;
         if (state == RUN) begin
            // An unacked request must still complete at the old address;
            // remember it so imem_addr stays stable while we wait.
            if (req && !bus.imem_ack) begin
               drop_addr <= pc_addr;
               state     <= DROP;
            end
         end else if (bus.imem_ack) begin
            state <= RUN;
         end
      end else if (state == DROP) begin
         // Buffer is empty here: DROP is only entered through a flush.
         if (bus.imem_ack) begin
            state <= RUN;
         end
      end else begin
`ifdef IF_FETCH_SKID_EN
         unique case ({push, pop})
            2'b10: begin
               if (count == 2'd0) head <= new_entry;
               else               tail <= new_entry;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd2) begin
                  head <= tail;
                  tail <= new_entry;
               end else begin
                  head <= new_entry;
               end
            end
            default: ;
         endcase
`else
         unique case ({push, pop})
            2'b10: begin
               head  <= new_entry;
               count <= 2'd1;
            end
            2'b01: begin
               count <= 2'd0;
            end
            2'b11: begin
               head <= new_entry;
            end
            default: ;
         endcase
`endif
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: self-checking bench for if_fetch.
// Models the PC register and an instruction memory with programmable ack
// latency (data = addr ^ 16'hA5A5), keeps a reference model of the fetch
// stage (RUN/DROP flag plus an expected queue of {pc, instr}) and compares
// the DUT against it every cycle.
module tb_if_fetch;
`ifdef IF_FETCH_SKID_EN
   localparam int DEPTH = 2;
`else
   localparam int DEPTH = 1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pc_addr = 16'h1234;
   logic        pc_en;
   logic        flush = 1'b0;
   logic        dbg_state;
   logic [1:0]  dbg_count;

   if_fetch_if bus();

   if_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .pc_addr   (pc_addr),
      .pc_en     (pc_en),
      .flush     (flush),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_count (dbg_count)
   );

   // clock
   always #5 clk = ~clk;

   // scoreboard and reference model state
   int          n_total = 0;
   int          n_bad   = 0;
   int          n_pops  = 0;
   int          lat     = 0;
   int          wait_cnt = 0;
   logic [31:0] exp_q[$];
   logic        m_drop = 1'b0;
   logic [15:0] m_drop_addr = 16'h0000;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_req();
      return m_drop || (exp_q.size() < DEPTH);
   endfunction

   // One clock cycle: drive inputs at negedge, answer memory, compare at
   // negedge+1, advance model, update PC just after the posedge.
   task automatic tick(input logic fl, input logic [15:0] tgt, input logic rdy);
      logic        m_req;
      logic        m_ack;
      logic        m_valid;
      logic        m_pc_en;
      logic [31:0] hd;
      @(negedge clk);
      flush        = fl;
      bus.id_ready = rdy;
      if (bus.imem_req && wait_cnt >= lat) begin
         bus.imem_ack   = 1'b1;
         bus.imem_rdata = bus.imem_addr ^ 16'hA5A5;
         wait_cnt       = 0;
      end else begin
         bus.imem_ack   = 1'b0;
         bus.imem_rdata = 16'($urandom);
         wait_cnt       = bus.imem_req ? wait_cnt + 1 : 0;
      end
      #1;
      m_req   = model_req();
      m_ack   = m_req && bus.imem_ack;
      m_valid = (exp_q.size() != 0) && !fl;
      m_pc_en = (!m_drop && m_ack) || fl;
      check("imem_req", 32'(bus.imem_req), 32'(m_req));
      if (m_req) check("imem_addr", 32'(bus.imem_addr), 32'(m_drop ? m_drop_addr : pc_addr));
      check("pc_en", 32'(pc_en), 32'(m_pc_en));
      check("id_valid", 32'(bus.id_valid), 32'(m_valid));
      check("state", 32'(dbg_state), 32'(m_drop));
      check("count", 32'(dbg_count), 32'(exp_q.size()));
      if (exp_q.size() == 0) begin
         check("empty_pc", 32'(bus.id_pc), 32'h0);
         check("empty_instr", 32'(bus.id_instr), 32'h0);
      end
      if (m_valid && rdy) begin
         hd = exp_q.pop_front();
         check("id_pc", 32'(bus.id_pc), 32'(hd[31:16]));
         check("id_instr", 32'(bus.id_instr), 32'(hd[15:0]));
         n_pops++;
      end
      if (fl) begin
         exp_q.delete();
         if (!m_drop) begin
            if (m_req && !bus.imem_ack) begin
               m_drop      = 1'b1;
               m_drop_addr = pc_addr;
            end
         end else if (bus.imem_ack) begin
            m_drop = 1'b0;
         end
      end else if (m_drop) begin
         if (bus.imem_ack) m_drop = 1'b0;
      end else if (m_ack) begin
         exp_q.push_back({pc_addr, pc_addr ^ 16'hA5A5});
      end
      @(posedge clk);
      #1;
      if (m_pc_en) pc_addr = fl ? tgt : pc_addr + 16'd2;
   endtask

   // Step until the model expects a request this cycle (bounded).
   task automatic wait_req(input logic rdy);
      int i;
      for (i = 0; i < 20 && !model_req(); i++) tick(1'b0, 16'h0000, rdy);
      if (!model_req()) check("wait_req_timeout", 32'h0, 32'h1);
   endtask

   // Reset with flush/ack held high to show outputs are forced during rst.
   task automatic do_reset();
      @(negedge clk);
      rst            = 1'b1;
      flush          = 1'b1;
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 16'hFFFF;
      bus.id_ready   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         if (i != 0) @(negedge clk);
         #1;
         check("rst_imem_req", 32'(bus.imem_req), 32'h0);
         check("rst_pc_en", 32'(pc_en), 32'h0);
         check("rst_id_valid", 32'(bus.id_valid), 32'h0);
         check("rst_imem_addr", 32'(bus.imem_addr), 32'h0);
         check("rst_id_pc", 32'(bus.id_pc), 32'h0);
         check("rst_id_instr", 32'(bus.id_instr), 32'h0);
         @(posedge clk);
         #1;
         pc_addr = 16'h0000;
      end
      rst          = 1'b0;
      flush        = 1'b0;
      bus.imem_ack = 1'b0;
      bus.id_ready = 1'b0;
      exp_q.delete();
      m_drop      = 1'b0;
      m_drop_addr = 16'h0000;
      wait_cnt    = 0;
      check("rst_state", 32'(dbg_state), 32'h0);
      check("rst_count", 32'(dbg_count), 32'h0);
   endtask

   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 16'h0000;
      bus.id_ready   = 1'b0;
      do_reset();

      // streaming, zero-wait memory
      lat = 0;
      for (int i = 0; i < 10; i++) tick(1'b0, 16'h0000, 1'b1);

      // backpressure then release
      for (int i = 0; i < 6; i++) tick(1'b0, 16'h0000, 1'b0);
      for (int i = 0; i < 8; i++) tick(1'b0, 16'h0000, 1'b1);

      // flush in the first cycle of a slow request
      lat = 3;
      wait_req(1'b1);
      tick(1'b1, 16'h0100, 1'b1);
      for (int i = 0; i < 12; i++) tick(1'b0, 16'h0000, 1'b1);

      // flush coincident with ack
      lat = 0;
      wait_req(1'b1);
      tick(1'b1, 16'h0200, 1'b1);
      for (int i = 0; i < 6; i++) tick(1'b0, 16'h0000, 1'b1);

      // flush with a full buffer
      for (int i = 0; i < 6; i++) tick(1'b0, 16'h0000, 1'b0);
      check("full_before_flush", 32'(dbg_count), 32'(DEPTH));
      tick(1'b1, 16'h0300, 1'b0);
      for (int i = 0; i < 8; i++) tick(1'b0, 16'h0000, 1'b1);

      // reset while in DROP, then restart from PC 0
      lat = 3;
      wait_req(1'b1);
      tick(1'b1, 16'h0400, 1'b1);
      tick(1'b0, 16'h0000, 1'b1);
      check("in_drop_before_rst", 32'(dbg_state), 32'h1);
      do_reset();
      lat = 0;
      for (int i = 0; i < 8; i++) tick(1'b0, 16'h0000, 1'b1);

      check("entries_delivered", 32'(n_pops > 10), 32'h1);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage sitting directly downstream of the PC register. Issues a read to instruction memory at the current PC over a req/ack handshake and drives `pc_en` to advance the PC when an instruction returns. Captures each {pc, instruction} pair in a small buffer and presents it to the decode stage over a valid/ready handshake. Discards in-flight and buffered fetches on a branch redirect (`flush`).

## Interface
- No parameters. Buffer depth `DEPTH` is set by configuration: 2 with `IF_FETCH_SKID_EN`, 1 without.
- `clk` in 1: clock, all state updates on posedge.
- `rst` in 1: reset rst, synchronous, active-high; clock clk.
- `pc_addr` in 16: current PC from the PC register.
- `pc_en` out 1: combinational; PC advances, or loads its branch target, at the next edge.
- `flush` in 1: branch redirect, same cycle the PC sees `branch_taken`.
- `imem_req` out 1: read request to instruction memory.
- `imem_addr` out 16: read address; stable while `imem_req` is high and unacked.
- `imem_ack` in 1: read data valid; counts only while `imem_req` is high; may arrive in the same cycle as the request.
- `imem_rdata` in 16: instruction word, sampled when `imem_ack` is high.
- `id_valid` out 1: buffer head valid toward decode.
- `id_ready` in 1: decode accepts the head.
- `id_instr` out 16: head instruction.
- `id_pc` out 16: head PC.

## Operation
- State: `RUN`/`DROP`, a DEPTH-entry FIFO of {pc, instr}, `count` (0..DEPTH), and 16-bit `drop_addr`.
- **RUN:**
  - `imem_req = (count < DEPTH)`, `imem_addr = pc_addr`.
  - The PC only changes on `pc_en`, so the address is stable until ack.
  - Once raised, `imem_req` stays high until ack, because `count` cannot rise without an ack.
  - On ack: push {pc_addr, imem_rdata} and assert `pc_en`.
- **DROP:**
  - `imem_req = 1`, `imem_addr = drop_addr`.
  - On ack: discard the data, no push, no `pc_en` (unless `flush`), go to RUN.
- **flush in RUN:**
  - Always: `pc_en = 1`, FIFO cleared, and the ack data of this cycle is discarded.
  - If `imem_req` was high and `imem_ack` was low: capture `drop_addr <= pc_addr` and go to DROP.
  - Otherwise stay in RUN.
- **flush in DROP:** `pc_en = 1`, FIFO cleared, stay in DROP with `drop_addr` unchanged. An ack in the same cycle returns to RUN.
- **Decode side:**
  - `id_valid = (count != 0) && !flush`.
  - Pop when `id_valid && id_ready`.
  - Push and pop in the same cycle leave `count` unchanged.
  - FIFO order is strict; `id_instr`/`id_pc` are 0 when `count == 0`.
- **pc_en:** `(state == RUN && imem_req && imem_ack) || flush`.
- **Reset:**
  - State and counters: state = RUN, `count = 0`, `drop_addr = 0`.
  - Outputs during `rst`: `imem_req`, `pc_en`, and `id_valid` forced 0; `id_instr`, `id_pc`, and `imem_addr` read 0.
  - In-flight fetch: `rst` abandons it; memory is reset by the same `rst`.

## Timing
- Zero-wait memory (ack in the request cycle, edge N): the PC holds pc+2 after edge N, and `id_valid` is high in the cycle after edge N with {pc, instr}.
- Throughput with `id_ready = 1`:
  - DEPTH 2: 1 fetch/cycle.
  - DEPTH 1: 1 fetch / 2 cycles, since a full buffer blocks the request in its pop cycle.
- `id_ready` low: fetches continue until `count == DEPTH`, then `imem_req` drops. It rises the cycle after the first pop.
- A flush with an outstanding request costs at least 1 cycle in DROP. The first redirected fetch issues in the cycle after DROP exits.
- No combinational path from `id_ready` to `imem_req`. Combinational paths exist from `imem_ack` and `flush` to `pc_en`, and from `flush` to `id_valid`.

## Configuration
- `IF_FETCH_SKID_EN` defined: DEPTH = 2, sustaining one instruction per cycle into decode.
- `IF_FETCH_SKID_EN` undefined: DEPTH = 1, one storage entry with full/empty flag, and half the peak throughput. All handshake and flush rules are unchanged.

## Test plan
- **Streaming:** zero-wait memory with `imem_rdata = addr ^ 16'hA5A5`, PC starting at 0, `id_ready = 1`. Decode receives pc 0, 2, 4, 6 on consecutive cycles (DEPTH 2) or every other cycle (DEPTH 1), with matching instructions.
- **Backpressure:** `id_ready = 0` for 6 cycles. `imem_req` deasserts once `count == DEPTH` with no lost or duplicated entries; after release the sequence resumes in order.
- **Flush with outstanding request:** 3-cycle ack latency, `flush` in the request cycle with branch target 16'h0100. `imem_addr` holds the old PC until ack, that data is discarded, and the next request is 16'h0100.
- **Flush coincident with ack:** `flush` and `imem_ack` in the same cycle. No push, `pc_en = 1`, no DROP, next request at the target.
- **Flush with full buffer:** buffer holds 2 entries and `flush` fires. `id_valid = 0` that cycle and the next; the old entries never appear.
- **Reset mid-fetch:** `rst` during DROP. After release, state is RUN, `count = 0`, and fetch restarts from the PC reset value 0.
